// File: rtl/cross_clock_data_handshake.sv
// Moves one DATA_WIDTH word from in_clk to out_clk using a toggle request and a
// toggle acknowledge. The in_clk side reports busy/ready, completion and dropped strobes.
module cross_clock_data_handshake #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  in_clk,
  input  logic                  rst,
  input  logic                  out_clk,
  input  logic                  in_stb,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  in_done,
  output logic                  in_overflow,
  output logic                  out_stb,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int unsigned SYNC_W = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  // ---------------- in_clk domain ----------------
  state_e                state_q, state_d;
  logic                  req_tgl_q, req_tgl_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [SYNC_W-1:0]     ack_sync_q;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  ack_edge;

  // ---------------- out_clk domain ---------------
  logic [SYNC_W-1:0]     req_sync_q;
  logic                  ack_tgl_q;
  logic                  out_stb_q;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  req_edge;

  assign ack_edge = ack_sync_q[SYNC_W-1] ^ ack_sync_q[SYNC_W-2];
  assign req_edge = req_sync_q[SYNC_W-1] ^ req_sync_q[SYNC_W-2];

  // Source-side state register and acknowledge synchroniser
  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_tgl_q  <= 1'b0;
      hold_q     <= '0;
      ack_sync_q <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_tgl_q  <= req_tgl_d;
      hold_q     <= hold_d;
      ack_sync_q <= {ack_sync_q[SYNC_W-2:0], ack_tgl_q};
      ready_q    <= ready_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  // Accept in IDLE; while waiting, every strobe (including the ack cycle) is an overflow
  always_comb begin
    state_d   = state_q;
    req_tgl_d = req_tgl_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_stb) begin
          hold_d    = in_data;
          req_tgl_d = ~req_tgl_q;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        ovf_d = in_stb;
        if (ack_edge) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // hold_q is static for several out_clk edges before it is sampled here
  always_comb begin
    out_data_d = out_data_q;
    if (req_edge) begin
      out_data_d = hold_q;
    end
  end

  // Destination-side request synchroniser, strobe, data capture and ack toggle
  always_ff @(posedge out_clk) begin
    if (rst) begin
      req_sync_q <= '0;
      ack_tgl_q  <= 1'b0;
      out_stb_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_W-2:0], req_tgl_q};
      ack_tgl_q  <= req_sync_q[SYNC_W-1];
      out_stb_q  <= req_edge;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready    = ready_q;
  assign in_done     = done_q;
  assign in_overflow = ovf_q;
  assign out_stb     = out_stb_q;
  assign out_data    = out_data_q;

endmodule

// File: doc/cross_clock_data_handshake.md
Name: cross_clock_data_handshake

Overview:
- Transfers one DATA_WIDTH word plus a strobe from the in_clk domain to the out_clk domain.
- Uses a toggle request in the forward direction and a toggle acknowledge in the return direction. The acknowledge is the return leg of the forward strobe crossing.
- in_clk side gets explicit busy/ready, done and overflow indications, so producers never lose a strobe silently.
- Used wherever a register write or command word must cross into a slower or unrelated clock domain.

Parameters:
- DATA_WIDTH, 32, width of the transferred word.

Ports:
- in_clk  input  1  source-domain clock.
- rst  input  1  reset, synchronous, active-high, sampled in both domains; held ≥4 cycles of the slower clock.
- out_clk  input  1  destination-domain clock.
- in_stb  input  1  single-cycle request; in_data is captured when in_stb && in_ready.
- in_data  input  DATA_WIDTH  word to transfer.
- in_ready  output  1  high when idle and a new in_stb will be accepted.
- in_done  output  1  one in_clk pulse when the destination has acknowledged the transfer.
- in_overflow  output  1  one in_clk pulse when in_stb arrives while busy; that strobe is dropped.
- out_stb  output  1  one out_clk pulse, new word valid.
- out_data  output  DATA_WIDTH  word held stable from out_stb until the next out_stb.

Behaviour:
- Reset values:
  - in_clk domain: busy=0, in_ready=1, in_done=0, in_overflow=0, req_tgl=0, hold=0, ack_sync=000.
  - out_clk domain: req_sync=000, ack_tgl=0, out_stb=0, out_data=0.
- in_clk domain FSM has two states, IDLE (busy=0) and WAIT_ACK (busy=1). in_ready = ~busy.
- IDLE, in_stb=1:
  - hold <= in_data and req_tgl <= ~req_tgl.
  - Go to WAIT_ACK; in_ready is 0 from the next cycle.
- WAIT_ACK, in_stb=1:
  - Strobe is dropped and hold is unchanged.
  - in_overflow=1 on the next cycle, for one cycle.
- ack_sync[2:0] <= {ack_sync[1:0], ack_tgl} every in_clk edge.
- ack_sync[2]^ack_sync[1]=1 in WAIT_ACK:
  - Next state IDLE and in_done=1 for one cycle.
  - in_stb in that same cycle counts as busy: it is dropped and flagged as overflow.
  - The earliest accepted follow-on strobe is the cycle in_done is high.
- out_clk domain:
  - req_sync[2:0] <= {req_sync[1:0], req_tgl} every edge.
  - out_stb <= req_sync[2]^req_sync[1].
  - When req_sync[2]^req_sync[1]=1, out_data <= hold in the same edge as out_stb is set.
  - hold is stable for ≥2 out_clk edges before sampling, so it is a quasi-static multi-bit crossing with no per-bit sync.
  - ack_tgl <= req_sync[2] every edge, so ack toggles one out_clk cycle after out_stb asserts.
- Latency:
  - in_stb (in_clk edge 0) to out_stb high: 3–4 out_clk edges after the req_tgl flip.
  - out_stb to in_done: 1 out_clk plus 3–4 in_clk edges.
  - With equal-frequency clocks, in_stb to in_done is ≤10 cycles.
- Edge cases:
  - Throughput is one word per round trip, and no strobe is ever lost without in_overflow.
  - An in_stb that is held high for several cycles is one transfer, and the remaining cycles count as overflow pulses while busy.
  - Reset mid-transfer returns both domains to reset values. No out_stb or in_done may be emitted for the aborted transfer after rst deasserts.
  - in_data changes while busy have no effect on out_data.

Test Plan:
- Equal 100 MHz clocks, rst 5 cycles, single in_stb with in_data=0xA5A5_0001 -> exactly one out_stb with out_data=0xA5A5_0001 within 4 out_clk edges, in_done within 10 in_clk cycles, in_ready low in between.
- in_clk 100 MHz, out_clk 33 MHz, 8 back-to-back words, each issued in the cycle in_done is high (0x10..0x17) -> 8 out_stb pulses in order with matching out_data, and zero in_overflow.
- in_stb on consecutive cycles 0x1,0x2,0x3 -> only 0x1 delivered, in_overflow pulses twice, exactly one in_done.
- in_stb in the cycle ack_sync edge is detected -> strobe dropped and in_overflow=1 alongside in_done=1.
- rst asserted 2 out_clk cycles after in_stb (before out_stb), held 4 slow cycles -> no out_stb, no in_done, in_ready=1, out_data=0 after reset.
- in_clk 25 MHz, out_clk 200 MHz, random words over 1000 transfers -> scoreboard exact match, each out_stb exactly 1 out_clk wide, each in_done exactly 1 in_clk wide.
